// File: rtl/seq_tracker_pkg.sv
// Shared definitions for the JK sequence-counter receive tracker: sequence table and FSM states.
package seq_tracker_pkg;

    localparam int SEQ_LEN = 8;

    // Counter code for each sequence index; index i lives at bits [i*4 +: 4].
    localparam logic [SEQ_LEN*4-1:0] SEQ_CODE_TBL = {
        4'd6, 4'd3, 4'd1, 4'd2, 4'd9, 4'd12, 4'd4, 4'd10
    };

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    function automatic logic [2:0] next_idx(input logic [2:0] idx);
        return idx + 3'd1;
    endfunction

endpackage

// File: rtl/seq_code_map.sv
// Combinational map from a 4-bit counter code to its sequence index and a legal flag.
// Zero latency, no flow control; unlisted codes give o_legal=0 and o_idx=0.
module seq_code_map
    import seq_tracker_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [2:0] o_idx,
    output logic       o_legal
);

    always_comb begin
        o_idx   = 3'd0;
        o_legal = 1'b0;
        for (int i = 0; i < SEQ_LEN; i++) begin
            if (i_code == SEQ_CODE_TBL[i*4 +: 4]) begin
                o_idx   = 3'(i);
                o_legal = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_tracker.sv
// Sequence tracker: decodes sampled counter codes, runs SEARCH/ACQ/LOCKED, flags ERR/ILLEGAL.
// Outputs registered, 1 cycle after the sampling edge; no backpressure, V=0 cycles are ignored. Option: SEQ_TRACKER_ERRCNT_EN.
module seq_tracker
    import seq_tracker_pkg::*;
#(
    parameter int LOCK_N   = 3,
    parameter int UNLOCK_N = 2,
    parameter int CNT_W    = 8
) (
    input  logic       C,
    input  logic       R,
    input  logic       V,
    input  logic [3:0] D,
    output logic [2:0] IDX,
    output logic       IDX_V,
    output logic       ILLEGAL,
    output logic       ERR,
    output logic       LOCK
`ifdef SEQ_TRACKER_ERRCNT_EN
    ,
    output logic [CNT_W-1:0] ERRCNT
`endif
);

    localparam logic [2:0] LOCK_N3   = 3'(LOCK_N);
    localparam logic [2:0] UNLOCK_N3 = 3'(UNLOCK_N);

    if (LOCK_N < 1 || LOCK_N > 7 || UNLOCK_N < 1 || UNLOCK_N > 7 || CNT_W < 1) begin : g_param_err
        $error("seq_tracker: parameter out of range");
    end

    state_t     r_state;
    logic [2:0] r_ref;
    logic [2:0] r_match;
    logic [2:0] r_miss;
    logic [2:0] r_idx;
    logic       r_idx_v;
    logic       r_illegal;
    logic       r_err;

    state_t     w_state_nxt;
    logic [2:0] w_ref_nxt;
    logic [2:0] w_match_nxt;
    logic [2:0] w_miss_nxt;
    logic       w_err_nxt;
    logic [2:0] w_idx;
    logic       w_legal;
    logic [2:0] w_exp;

    seq_code_map u_map (
        .i_code  (D),
        .o_idx   (w_idx),
        .o_legal (w_legal)
    );

    assign w_exp = next_idx(r_ref);

    always_comb begin
        w_state_nxt = r_state;
        w_ref_nxt   = r_ref;
        w_match_nxt = r_match;
        w_miss_nxt  = r_miss;
        w_err_nxt   = 1'b0;
        if (V) begin
            case (r_state)
                ST_SEARCH: begin
                    if (w_legal) begin
                        w_ref_nxt   = w_idx;
                        w_match_nxt = 3'd0;
                        w_state_nxt = ST_ACQ;
                    end
                end
                ST_ACQ: begin
                    if (!w_legal) begin
                        w_state_nxt = ST_SEARCH;
                    end else if (w_idx == w_exp) begin
                        w_ref_nxt   = w_idx;
                        w_match_nxt = r_match + 3'd1;
                        if (w_match_nxt == LOCK_N3) begin
                            w_state_nxt = ST_LOCKED;
                            w_miss_nxt  = 3'd0;
                        end
                    end else begin
                        w_ref_nxt   = w_idx;
                        w_match_nxt = 3'd0;
                    end
                end
                ST_LOCKED: begin
                    if (w_legal && (w_idx == w_exp)) begin
                        w_ref_nxt  = w_idx;
                        w_miss_nxt = 3'd0;
                    end else begin
                        // Flywheel: keep counting the expected sequence through the bad sample.
                        w_err_nxt  = 1'b1;
                        w_ref_nxt  = w_exp;
                        w_miss_nxt = r_miss + 3'd1;
                        if (w_miss_nxt == UNLOCK_N3) begin
                            w_state_nxt = ST_SEARCH;
                        end
                    end
                end
                default: w_state_nxt = ST_SEARCH;
            endcase
        end
    end

    always_ff @(posedge C) begin
        if (R) begin
            r_state   <= ST_SEARCH;
            r_ref     <= 3'd0;
            r_match   <= 3'd0;
            r_miss    <= 3'd0;
            r_idx     <= 3'd0;
            r_idx_v   <= 1'b0;
            r_illegal <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ref     <= w_ref_nxt;
            r_match   <= w_match_nxt;
            r_miss    <= w_miss_nxt;
            r_idx_v   <= V && w_legal;
            r_illegal <= V && !w_legal;
            r_err     <= w_err_nxt;
            if (V && w_legal) begin
                r_idx <= w_idx;
            end
        end
    end

    assign IDX     = r_idx;
    assign IDX_V   = r_idx_v;
    assign ILLEGAL = r_illegal;
    assign ERR     = r_err;
    assign LOCK    = (r_state == ST_LOCKED);

`ifdef SEQ_TRACKER_ERRCNT_EN
    logic [CNT_W-1:0] r_errcnt;

    always_ff @(posedge C) begin
        if (R) begin
            r_errcnt <= '0;
        end else if (w_err_nxt && (r_errcnt != {CNT_W{1'b1}})) begin
            r_errcnt <= r_errcnt + 1'b1;
        end
    end

    assign ERRCNT = r_errcnt;
`endif

endmodule

// File: tb/tb_seq_tracker.sv
// Directed table-driven bench for seq_tracker, plus hand sequences for unlock depth and the error counter.
module tb_seq_tracker;

    logic       C = 1'b0;
    logic       R = 1'b1;
    logic       V = 1'b0;
    logic [3:0] D = 4'd0;

    logic [2:0] idx_a, idx_b, idx_c;
    logic       iv_a, iv_b, iv_c;
    logic       ill_a, ill_b, ill_c;
    logic       err_a, err_b, err_c;
    logic       lock_a, lock_b, lock_c;

    int n_checks = 0;
    int n_err    = 0;

    always #5 C = ~C;

`ifdef SEQ_TRACKER_ERRCNT_EN
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;

    seq_tracker #(.LOCK_N(3), .UNLOCK_N(2)) u_a (
        .C(C), .R(R), .V(V), .D(D), .IDX(idx_a), .IDX_V(iv_a), .ILLEGAL(ill_a),
        .ERR(err_a), .LOCK(lock_a), .ERRCNT(cnt_a));
    seq_tracker #(.LOCK_N(3), .UNLOCK_N(3)) u_b (
        .C(C), .R(R), .V(V), .D(D), .IDX(idx_b), .IDX_V(iv_b), .ILLEGAL(ill_b),
        .ERR(err_b), .LOCK(lock_b), .ERRCNT(cnt_b));
    seq_tracker #(.LOCK_N(3), .UNLOCK_N(7), .CNT_W(2)) u_c (
        .C(C), .R(R), .V(V), .D(D), .IDX(idx_c), .IDX_V(iv_c), .ILLEGAL(ill_c),
        .ERR(err_c), .LOCK(lock_c), .ERRCNT(cnt_c));
`else
    seq_tracker #(.LOCK_N(3), .UNLOCK_N(2)) u_a (
        .C(C), .R(R), .V(V), .D(D), .IDX(idx_a), .IDX_V(iv_a), .ILLEGAL(ill_a),
        .ERR(err_a), .LOCK(lock_a));
    seq_tracker #(.LOCK_N(3), .UNLOCK_N(3)) u_b (
        .C(C), .R(R), .V(V), .D(D), .IDX(idx_b), .IDX_V(iv_b), .ILLEGAL(ill_b),
        .ERR(err_b), .LOCK(lock_b));
    seq_tracker #(.LOCK_N(3), .UNLOCK_N(7)) u_c (
        .C(C), .R(R), .V(V), .D(D), .IDX(idx_c), .IDX_V(iv_c), .ILLEGAL(ill_c),
        .ERR(err_c), .LOCK(lock_c));
`endif

    typedef struct {
        logic       r;
        logic       v;
        logic [3:0] d;
        logic [2:0] idx;
        logic       iv;
        logic       ill;
        logic       err;
        logic       lock;
        logic       lock_b;
    } vec_t;

    localparam int NVEC = 45;
    vec_t tbl [NVEC];

    function automatic vec_t mk(input logic r, input logic v, input logic [3:0] d,
                                input logic [2:0] idx, input logic iv, input logic ill,
                                input logic err, input logic lock, input logic lock_b);
        vec_t t;
        t.r = r; t.v = v; t.d = d; t.idx = idx; t.iv = iv;
        t.ill = ill; t.err = err; t.lock = lock; t.lock_b = lock_b;
        return t;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one input set, then sample the registered result at the next falling edge.
    task automatic step(input logic r, input logic v, input logic [3:0] d);
        R = r;
        V = v;
        D = d;
        @(negedge C);
    endtask

    initial begin
        //          r  v  d    idx iv ill err lk lkb
        tbl[0]  = mk(1, 0, 0,   0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 1, 10,  0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 10,  0, 1, 0, 0, 0, 0);
        tbl[3]  = mk(0, 1, 4,   1, 1, 0, 0, 0, 0);
        tbl[4]  = mk(0, 1, 12,  2, 1, 0, 0, 0, 0);
        tbl[5]  = mk(0, 1, 9,   3, 1, 0, 0, 1, 1);
        tbl[6]  = mk(0, 0, 0,   3, 0, 0, 0, 1, 1);
        tbl[7]  = mk(0, 1, 2,   4, 1, 0, 0, 1, 1);
        tbl[8]  = mk(0, 1, 1,   5, 1, 0, 0, 1, 1);
        tbl[9]  = mk(0, 1, 3,   6, 1, 0, 0, 1, 1);
        tbl[10] = mk(0, 1, 6,   7, 1, 0, 0, 1, 1);
        tbl[11] = mk(0, 1, 10,  0, 1, 0, 0, 1, 1);
        tbl[12] = mk(0, 1, 0,   0, 0, 1, 1, 1, 1);
        tbl[13] = mk(0, 1, 12,  2, 1, 0, 0, 1, 1);
        tbl[14] = mk(0, 1, 2,   4, 1, 0, 1, 1, 1);
        tbl[15] = mk(0, 1, 1,   5, 1, 0, 1, 0, 1);
        tbl[16] = mk(0, 1, 15,  5, 0, 1, 0, 0, 0);
        tbl[17] = mk(0, 1, 10,  0, 1, 0, 0, 0, 0);
        tbl[18] = mk(0, 0, 10,  0, 0, 0, 0, 0, 0);
        tbl[19] = mk(0, 1, 4,   1, 1, 0, 0, 0, 0);
        tbl[20] = mk(0, 0, 0,   1, 0, 0, 0, 0, 0);
        tbl[21] = mk(0, 0, 0,   1, 0, 0, 0, 0, 0);
        tbl[22] = mk(0, 1, 12,  2, 1, 0, 0, 0, 0);
        tbl[23] = mk(0, 0, 0,   2, 0, 0, 0, 0, 0);
        tbl[24] = mk(0, 1, 9,   3, 1, 0, 0, 1, 1);
        tbl[25] = mk(0, 0, 0,   3, 0, 0, 0, 1, 1);
        tbl[26] = mk(1, 1, 6,   0, 0, 0, 0, 0, 0);
        tbl[27] = mk(0, 1, 10,  0, 1, 0, 0, 0, 0);
        tbl[28] = mk(0, 1, 4,   1, 1, 0, 0, 0, 0);
        tbl[29] = mk(0, 1, 12,  2, 1, 0, 0, 0, 0);
        tbl[30] = mk(0, 1, 9,   3, 1, 0, 0, 1, 1);
        tbl[31] = mk(1, 0, 0,   0, 0, 0, 0, 0, 0);
        tbl[32] = mk(0, 1, 10,  0, 1, 0, 0, 0, 0);
        tbl[33] = mk(0, 1, 12,  2, 1, 0, 0, 0, 0);
        tbl[34] = mk(0, 1, 9,   3, 1, 0, 0, 0, 0);
        tbl[35] = mk(0, 1, 2,   4, 1, 0, 0, 0, 0);
        tbl[36] = mk(0, 1, 1,   5, 1, 0, 0, 1, 1);
        tbl[37] = mk(1, 0, 0,   0, 0, 0, 0, 0, 0);
        tbl[38] = mk(0, 1, 10,  0, 1, 0, 0, 0, 0);
        tbl[39] = mk(0, 1, 4,   1, 1, 0, 0, 0, 0);
        tbl[40] = mk(0, 1, 7,   1, 0, 1, 0, 0, 0);
        tbl[41] = mk(0, 1, 12,  2, 1, 0, 0, 0, 0);
        tbl[42] = mk(0, 1, 9,   3, 1, 0, 0, 0, 0);
        tbl[43] = mk(0, 1, 2,   4, 1, 0, 0, 0, 0);
        tbl[44] = mk(0, 1, 1,   5, 1, 0, 0, 1, 1);

        for (int i = 0; i < NVEC; i++) begin
            step(tbl[i].r, tbl[i].v, tbl[i].d);
            chk($sformatf("v%0d.IDX", i),     int'(idx_a),  int'(tbl[i].idx));
            chk($sformatf("v%0d.IDX_V", i),   int'(iv_a),   int'(tbl[i].iv));
            chk($sformatf("v%0d.ILLEGAL", i), int'(ill_a),  int'(tbl[i].ill));
            chk($sformatf("v%0d.ERR", i),     int'(err_a),  int'(tbl[i].err));
            chk($sformatf("v%0d.LOCK", i),    int'(lock_a), int'(tbl[i].lock));
            chk($sformatf("v%0d.LOCK_U3", i), int'(lock_b), int'(tbl[i].lock_b));
        end

        // Three-deep unlock: a good sample between errors restarts the miss count.
        step(1, 0, 0);
        step(0, 1, 10);
        step(0, 1, 4);
        step(0, 1, 12);
        step(0, 1, 9);
        chk("u3.lock_up", int'(lock_b), 1);
        step(0, 1, 0);
        chk("u3.e1.ERR", int'(err_b), 1);
        step(0, 1, 0);
        chk("u3.e2.ERR", int'(err_b), 1);
        chk("u3.e2.LOCK", int'(lock_b), 1);
        step(0, 1, 3);
        chk("u3.good.ERR", int'(err_b), 0);
        chk("u3.good.IDX", int'(idx_b), 6);
        chk("u3.good.LOCK", int'(lock_b), 1);
        step(0, 1, 0);
        chk("u3.e3.ERR", int'(err_b), 1);
        step(0, 1, 0);
        chk("u3.e4.LOCK", int'(lock_b), 1);
        step(0, 1, 0);
        chk("u3.e5.ERR", int'(err_b), 1);
        chk("u3.e5.LOCK", int'(lock_b), 0);

`ifdef SEQ_TRACKER_ERRCNT_EN
        begin
            logic [1:0] exp_cnt [5];
            exp_cnt[0] = 2'd1;
            exp_cnt[1] = 2'd2;
            exp_cnt[2] = 2'd3;
            exp_cnt[3] = 2'd3;
            exp_cnt[4] = 2'd3;
            step(1, 1, 0);
            chk("cnt.reset", int'(cnt_c), 0);
            step(0, 1, 10);
            step(0, 1, 4);
            step(0, 1, 12);
            step(0, 1, 9);
            chk("cnt.lock", int'(lock_c), 1);
            chk("cnt.pre", int'(cnt_c), 0);
            for (int k = 0; k < 5; k++) begin
                step(0, 1, 0);
                chk($sformatf("cnt.e%0d", k), int'(cnt_c), int'(exp_cnt[k]));
                chk($sformatf("cnt.e%0d.ERR", k), int'(err_c), 1);
            end
            chk("cnt.still_locked", int'(lock_c), 1);
        end
`endif

        R = 1'b0;
        V = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
